pc_gen: RTL and testbench

- Program-counter generation and fetch-request stage of the RISC-V core.
- Consumes the branch comparator's should_branch result, plus the jump indications and targets from EX.
- Drives the instruction-memory fetch address with a valid/ready handshake.
- Issues the pipeline flush on redirect and raises a misaligned-target trap, holding fetch until the trap is acknowledged.

---
 rtl/pc_gen.sv | 151 +++++++++++++++
 tb/tb_pc_gen.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : pc_gen
// Brief    : PC generation / fetch-request stage with redirect flush and
//            misaligned-target trap. Optional macro BRANCH_STATS_EN adds
//            saturating branch counters (br_count, br_taken_count).
// Revision : 1.0 - initial release
// ============================================================================
module pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        is_branch,
  input  logic        should_branch,
  input  logic        is_jump,
  input  logic [31:0] target,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic        trap_ack,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic        flush,
  output logic        trap,
`ifdef BRANCH_STATS_EN
  output logic [31:0] trap_addr,
  output logic [31:0] br_count,
  output logic [31:0] br_taken_count
`else
  output logic [31:0] trap_addr
`endif
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2,
    TRAP  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_trap_addr;
  logic [31:0] w_trap_addr_nxt;
  logic        r_flush;
  logic        w_flush_nxt;
  logic        r_trap;
  logic        w_trap_nxt;
  logic        w_redirect;
  logic        w_misaligned;

  assign w_redirect   = ex_valid & (is_jump | (is_branch & should_branch));
  assign w_misaligned = (target[1:0] != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= BOOT;
      r_pc        <= RESET_PC;
      r_trap_addr <= 32'h0;
      r_flush     <= 1'b0;
      r_trap      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_trap_addr <= w_trap_addr_nxt;
      r_flush     <= w_flush_nxt;
      r_trap      <= w_trap_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_trap_addr_nxt = r_trap_addr;
    w_flush_nxt     = 1'b0;
    w_trap_nxt      = r_trap;
    case (r_state)
      BOOT: begin
        w_state_nxt = FETCH;
      end
      FETCH: begin
        if (w_redirect && w_misaligned) begin
          w_trap_nxt      = 1'b1;
          w_trap_addr_nxt = target;
          w_state_nxt     = TRAP;
        end else if (w_redirect) begin
          // Redirect beats stall: an unaccepted request may be dropped safely.
          w_pc_nxt    = target;
          w_flush_nxt = 1'b1;
          w_state_nxt = FLUSH;
        end else if (stall) begin
          w_pc_nxt = r_pc;
        end else if (imem_ready) begin
          w_pc_nxt = r_pc + 32'd4;
        end
      end
      FLUSH: begin
        // EX is being killed this cycle, so any redirect it shows is stale.
        w_state_nxt = FETCH;
      end
      TRAP: begin
        if (trap_ack) begin
          w_pc_nxt    = TRAP_VEC;
          w_trap_nxt  = 1'b0;
          w_flush_nxt = 1'b1;
          w_state_nxt = FLUSH;
        end
      end
      default: begin
        w_state_nxt = BOOT;
      end
    endcase
  end

  assign pc        = r_pc;
  assign pc_valid  = (r_state == FETCH);
  assign flush     = r_flush;
  assign trap      = r_trap;
  assign trap_addr = r_trap_addr;

`ifdef BRANCH_STATS_EN
  logic [31:0] r_br_count;
  logic [31:0] r_br_taken_count;
  logic        w_br_seen;

  assign w_br_seen = (r_state == FETCH) & ex_valid & is_branch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_br_count       <= 32'h0;
      r_br_taken_count <= 32'h0;
    end else if (w_br_seen) begin
      if (r_br_count != 32'hFFFF_FFFF) begin
        r_br_count <= r_br_count + 32'd1;
      end
      if (should_branch && (r_br_taken_count != 32'hFFFF_FFFF)) begin
        r_br_taken_count <= r_br_taken_count + 32'd1;
      end
    end
  end

  assign br_count       = r_br_count;
  assign br_taken_count = r_br_taken_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_gen
// Brief    : Directed self-checking bench for pc_gen (BRANCH_STATS_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_gen;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        is_branch;
  logic        should_branch;
  logic        is_jump;
  logic [31:0] target;
  logic        stall;
  logic        imem_ready;
  logic        trap_ack;
  logic [31:0] pc;
  logic        pc_valid;
  logic        flush;
  logic        trap;
  logic [31:0] trap_addr;
`ifdef BRANCH_STATS_EN
  logic [31:0] br_count;
  logic [31:0] br_taken_count;
`endif

  int n_checks;
  int n_pass;

  pc_gen #(
    .RESET_PC(32'h0000_0000),
    .TRAP_VEC(32'h0000_0100)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .is_branch     (is_branch),
    .should_branch (should_branch),
    .is_jump       (is_jump),
    .target        (target),
    .stall         (stall),
    .imem_ready    (imem_ready),
    .trap_ack      (trap_ack),
    .pc            (pc),
    .pc_valid      (pc_valid),
    .flush         (flush),
    .trap          (trap),
`ifdef BRANCH_STATS_EN
    .trap_addr     (trap_addr),
    .br_count      (br_count),
    .br_taken_count(br_taken_count)
`else
    .trap_addr     (trap_addr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid      = 1'b0;
    is_branch     = 1'b0;
    should_branch = 1'b0;
    is_jump       = 1'b0;
    target        = 32'h0;
    stall         = 1'b0;
    trap_ack      = 1'b0;
  endtask

  task automatic expect_fetch(input string tag, input logic [31:0] exp_pc);
    check({tag, "_pc"}, pc, exp_pc);
    check({tag, "_valid"}, {31'b0, pc_valid}, 32'd1);
    check({tag, "_flush"}, {31'b0, flush}, 32'd0);
  endtask

  task automatic expect_flush(input string tag, input logic [31:0] exp_pc);
    check({tag, "_flush"}, {31'b0, flush}, 32'd1);
    check({tag, "_valid"}, {31'b0, pc_valid}, 32'd0);
    check({tag, "_pc"}, pc, exp_pc);
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    idle_inputs();
    imem_ready = 1'b1;
    rst        = 1'b1;
    tick();
    tick();
    check("rst_pc", pc, 32'h0);
    check("rst_valid", {31'b0, pc_valid}, 32'd0);
    check("rst_flush", {31'b0, flush}, 32'd0);
    check("rst_trap", {31'b0, trap}, 32'd0);
    check("rst_taddr", trap_addr, 32'h0);

    // Boot cycle then sequential fetch.
    rst = 1'b0;
    #1;
    check("boot_pc", pc, 32'h0);
    check("boot_valid", {31'b0, pc_valid}, 32'd0);
    tick(); expect_fetch("seq0", 32'h0);
    tick(); expect_fetch("seq4", 32'h4);
    tick(); expect_fetch("seq8", 32'h8);
    tick(); tick(); expect_fetch("seq10", 32'h10);

    // Taken branch to 0x40; redirect shown during FLUSH must be ignored.
    ex_valid = 1'b1; is_branch = 1'b1; should_branch = 1'b1; target = 32'h40;
    tick(); expect_flush("br_fl", 32'h40);
    target = 32'h200;
    tick(); expect_fetch("br_tgt", 32'h40);
    idle_inputs();

    // Aligned jump to 0x20, then not-taken branch and stall.
    ex_valid = 1'b1; is_jump = 1'b1; target = 32'h20;
    tick(); expect_flush("jmp_fl", 32'h20);
    idle_inputs();
    tick(); expect_fetch("jmp_tgt", 32'h20);
    ex_valid = 1'b1; is_branch = 1'b1; should_branch = 1'b0; target = 32'h80;
    tick(); expect_fetch("nt_inc", 32'h24);
    idle_inputs();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); expect_fetch("stall", 32'h24);
    end
    stall = 1'b0;
    ex_valid = 1'b0; is_jump = 1'b1; target = 32'h300;
    tick(); expect_fetch("noval_jmp", 32'h28);
    idle_inputs();
    imem_ready = 1'b0;
    tick(); expect_fetch("not_ready", 32'h28);
    imem_ready = 1'b1;

    // Misaligned jump traps; fetch held until acknowledge.
    ex_valid = 1'b1; is_jump = 1'b1; target = 32'h102;
    tick();
    check("trap_set", {31'b0, trap}, 32'd1);
    check("trap_addr", trap_addr, 32'h102);
    check("trap_flush", {31'b0, flush}, 32'd0);
    check("trap_pc", pc, 32'h28);
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("trap_hold", {31'b0, trap}, 32'd1);
      check("trap_hold_valid", {31'b0, pc_valid}, 32'd0);
    end
    trap_ack = 1'b1;
    tick(); expect_flush("ack_fl", 32'h100);
    check("ack_trap", {31'b0, trap}, 32'd0);
    trap_ack = 1'b0;
    tick(); expect_fetch("trap_vec", 32'h100);
    check("taddr_keep", trap_addr, 32'h102);

    // Wrap-around and redirect winning over stall.
    ex_valid = 1'b1; is_jump = 1'b1; target = 32'hFFFF_FFFC;
    tick(); idle_inputs();
    tick(); expect_fetch("top", 32'hFFFF_FFFC);
    tick(); expect_fetch("wrap", 32'h0);
    stall = 1'b1; ex_valid = 1'b1; is_branch = 1'b1; should_branch = 1'b1; target = 32'h80;
    tick(); expect_flush("stl_br_fl", 32'h80);
    idle_inputs();
    tick(); expect_fetch("stl_br", 32'h80);

    // Two more branches: one not taken, one taken (totals 5 seen / 3 taken).
    ex_valid = 1'b1; is_branch = 1'b1; should_branch = 1'b0; target = 32'h90;
    tick(); expect_fetch("nt2", 32'h84);
    should_branch = 1'b1;
    tick(); expect_flush("tk3_fl", 32'h90);
    idle_inputs();
    tick(); expect_fetch("tk3", 32'h90);
`ifdef BRANCH_STATS_EN
    check("br_count", br_count, 32'd5);
    check("br_taken", br_taken_count, 32'd3);
`endif

    // Asynchronous reset mid-cycle.
    #2;
    rst = 1'b1;
    #1;
    check("arst_pc", pc, 32'h0);
    check("arst_valid", {31'b0, pc_valid}, 32'd0);
    check("arst_taddr", trap_addr, 32'h0);
`ifdef BRANCH_STATS_EN
    check("arst_brc", br_count, 32'd0);
    check("arst_brt", br_taken_count, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
